// File: rtl/eeprom_i2c_slave.sv
// eeprom_i2c_slave: I2C byte-addressed EEPROM slave with block bits, page-wrapped writes and sequential reads
module eeprom_i2c_slave #(
  parameter int         ADDR_W = 11,
  parameter logic [3:0] DEV_ID = 4'b1010,
  parameter int         PAGE_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe,
  input  logic wp,
  output logic busy
);
  typedef enum logic [3:0] {
    IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;
  state_t            state_q;
  logic [1:0]        scl_sync_q, sda_sync_q;
  logic              scl_d_q, sda_d_q;
  logic [3:0]        cnt_q;
  logic [7:0]        sh_q;
  logic [2:0]        blk_q;
  logic [ADDR_W-1:0] addr_q, addr_ld, addr_pg;
  logic              ack_q;
  logic [7:0]        mem_q [2**ADDR_W];
  logic              scl, sda, scl_rise, scl_fall, start, stop, mem_we;
  logic [7:0]        byte_in, rd_byte;
  assign scl      = scl_sync_q[1];
  assign sda      = sda_sync_q[1];
  assign scl_rise = scl & ~scl_d_q;
  assign scl_fall = ~scl & scl_d_q;
  assign start    = scl & scl_d_q & sda_d_q & ~sda;
  assign stop     = scl & scl_d_q & ~sda_d_q & sda;
  assign byte_in  = {sh_q[6:0], sda};
  assign rd_byte  = mem_q[addr_q];
  assign addr_pg  = {addr_q[ADDR_W-1:PAGE_W], addr_q[PAGE_W-1:0] + PAGE_W'(1)};
  assign mem_we   = !rst && state_q == WDATA && scl_rise && cnt_q == 4'd7 && !wp;
  assign busy     = state_q != IDLE;
  if (ADDR_W > 8) begin : g_blk
    assign addr_ld = {blk_q[ADDR_W-9:0], sh_q};
  end else begin : g_noblk
    assign addr_ld = sh_q;
  end
  always_ff @(posedge clk) if (mem_we) mem_q[addr_q] <= byte_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_d_q    <= 1'b1;
      sda_d_q    <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      blk_q      <= '0;
      addr_q     <= '0;
      ack_q      <= 1'b0;
      sda_oe     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_d_q    <= scl;
      sda_d_q    <= sda;
      if (start) begin
        state_q <= CTRL;
        cnt_q   <= '0;
        sda_oe  <= 1'b0;
      end else if (stop) begin
        state_q <= IDLE;
        sda_oe  <= 1'b0;
      end else begin
        case (state_q)
          CTRL, ADDR:
            if (scl_rise) begin
              sh_q  <= byte_in;
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              if (state_q == ADDR) begin
                addr_q  <= addr_ld;
                state_q <= ADDR_ACK;
                sda_oe  <= 1'b1;
              end else begin
                state_q <= sh_q[7:4] == DEV_ID ? CTRL_ACK : WAIT_STOP;
                sda_oe  <= sh_q[7:4] == DEV_ID;
              end
            end
          // Control byte is still in sh_q here; a read preloads the byte at the current address
          CTRL_ACK:
            if (scl_fall) begin
              blk_q   <= sh_q[3:1];
              cnt_q   <= '0;
              state_q <= sh_q[0] ? RDATA : ADDR;
              sh_q    <= rd_byte;
              sda_oe  <= sh_q[0] & ~rd_byte[7];
            end
          ADDR_ACK, WDATA_ACK:
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              cnt_q   <= '0;
              state_q <= WDATA;
            end
          WDATA:
            if (scl_rise) begin
              sh_q  <= byte_in;
              cnt_q <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                ack_q <= ~wp;
                if (!wp) addr_q <= addr_pg;
              end
            end else if (scl_fall && cnt_q == 4'd8) begin
              state_q <= ack_q ? WDATA_ACK : WAIT_STOP;
              sda_oe  <= ack_q;
            end
          RDATA:
            if (scl_rise) cnt_q <= cnt_q + 4'd1;
            else if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                sda_oe  <= 1'b0;
                addr_q  <= addr_q + ADDR_W'(1);
                state_q <= RDATA_ACK;
              end else begin
                sda_oe <= ~sh_q[6];
                sh_q   <= {sh_q[6:0], 1'b0};
              end
            end
          RDATA_ACK:
            if (scl_rise) ack_q <= ~sda;
            else if (scl_fall) begin
              cnt_q   <= '0;
              state_q <= ack_q ? RDATA : WAIT_STOP;
              sh_q    <= rd_byte;
              sda_oe  <= ack_q & ~rd_byte[7];
            end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_eeprom_i2c_slave.sv
// tb_eeprom_i2c_slave: directed I2C master transactions against eeprom_i2c_slave with hand-computed expectations
module tb_eeprom_i2c_slave;
  localparam time Q = 80ns;
  logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1, wp = 1'b0;
  logic sda_oe, busy, sda_line;
  logic mon = 1'b0, oe_seen = 1'b0;
  int   n_cmp = 0, n_bad = 0;
  assign sda_line = sda_m & ~sda_oe;
  eeprom_i2c_slave dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe(sda_oe), .wp(wp), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mon && sda_oe) oe_seen <= 1'b1;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic bit_io(input logic b, output logic r);
    sda_m = b;
    #Q scl_m = 1'b1;
    #Q r = sda_line;
    #Q scl_m = 1'b0;
    #Q;
  endtask
  task automatic start_c();
    sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b0;
    #Q;
  endtask
  task automatic stop_c();
    sda_m = 1'b0;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask
  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(d[i], r);
    bit_io(1'b1, r);
    ack = ~r;
  endtask
  task automatic rbyte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      d[i] = r;
    end
    bit_io(nack, r);
  endtask
  task automatic set_addr(input logic [7:0] ctrl, input logic [7:0] a);
    logic ack;
    start_c();
    wbyte(ctrl, ack);
    chk("set_ctrl_ack", {7'd0, ack}, 8'd1);
    wbyte(a, ack);
    chk("set_addr_ack", {7'd0, ack}, 8'd1);
  endtask
  initial begin
    logic       ack;
    logic [7:0] d;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("reset_oe", {7'd0, sda_oe}, 8'd0);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    rst = 1'b0;
    #40;
    // Single write then random read back
    set_addr(8'hA0, 8'h12);
    wbyte(8'h5A, ack);
    chk("wr_data_ack", {7'd0, ack}, 8'd1);
    stop_c();
    #Q chk("busy_after_wr_stop", {7'd0, busy}, 8'd0);
    set_addr(8'hA0, 8'h12);
    start_c();
    wbyte(8'hA1, ack);
    chk("rd_ctrl_ack", {7'd0, ack}, 8'd1);
    rbyte(1'b1, d);
    chk("rd_5a", d, 8'h5A);
    stop_c();
    // Page wrap: 0x0E,0x0F,0x00,0x01
    set_addr(8'hA0, 8'h0E);
    for (int i = 0; i < 4; i++) begin
      wbyte(8'h10 + 8'(i), ack);
      chk("page_wr_ack", {7'd0, ack}, 8'd1);
    end
    stop_c();
    set_addr(8'hA0, 8'h0E);
    start_c();
    wbyte(8'hA1, ack);
    rbyte(1'b0, d);
    chk("page_0e", d, 8'h10);
    rbyte(1'b1, d);
    chk("page_0f", d, 8'h11);
    stop_c();
    set_addr(8'hA0, 8'h00);
    start_c();
    wbyte(8'hA1, ack);
    rbyte(1'b0, d);
    chk("page_00", d, 8'h12);
    rbyte(1'b1, d);
    chk("page_01", d, 8'h13);
    stop_c();
    // Block bits: 0x7FF then sequential read wraps to 0x000
    set_addr(8'hAE, 8'hFF);
    wbyte(8'h77, ack);
    chk("blk_wr_ack", {7'd0, ack}, 8'd1);
    stop_c();
    set_addr(8'hAE, 8'hFF);
    start_c();
    wbyte(8'hAF, ack);
    chk("blk_rd_ctrl_ack", {7'd0, ack}, 8'd1);
    rbyte(1'b0, d);
    chk("blk_7ff", d, 8'h77);
    rbyte(1'b1, d);
    chk("blk_wrap_000", d, 8'h12);
    stop_c();
    // Foreign device code
    mon = 1'b1;
    start_c();
    wbyte(8'h90, ack);
    chk("foreign_nack", {7'd0, ack}, 8'd0);
    wbyte(8'h12, ack);
    chk("foreign_busy", {7'd0, busy}, 8'd1);
    stop_c();
    #Q;
    mon = 1'b0;
    chk("foreign_oe_quiet", {7'd0, oe_seen}, 8'd0);
    chk("foreign_busy_after_stop", {7'd0, busy}, 8'd0);
    // Write protect
    set_addr(8'hA0, 8'h20);
    wbyte(8'h44, ack);
    stop_c();
    wp = 1'b1;
    set_addr(8'hA0, 8'h20);
    wbyte(8'h33, ack);
    chk("wp_data_nack", {7'd0, ack}, 8'd0);
    stop_c();
    wp = 1'b0;
    set_addr(8'hA0, 8'h20);
    start_c();
    wbyte(8'hA1, ack);
    rbyte(1'b1, d);
    chk("wp_prior_value", d, 8'h44);
    stop_c();
    // Reset during the 4th data bit of a read of 0x44 (bit value 0 -> oe driven)
    set_addr(8'hA0, 8'h20);
    start_c();
    wbyte(8'hA1, ack);
    for (int i = 0; i < 3; i++) bit_io(1'b1, ack);
    sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q chk("rst_pre_oe", {7'd0, sda_oe}, 8'd1);
    rst = 1'b1;
    #10;
    chk("rst_oe", {7'd0, sda_oe}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    rst = 1'b0;
    #Q scl_m = 1'b0;
    #Q;
    stop_c();
    start_c();
    wbyte(8'hA1, ack);
    chk("post_rst_ctrl_ack", {7'd0, ack}, 8'd1);
    rbyte(1'b1, d);
    chk("post_rst_addr0", d, 8'h12);
    stop_c();
    set_addr(8'hA0, 8'h20);
    start_c();
    wbyte(8'hA1, ack);
    rbyte(1'b1, d);
    chk("post_rst_20", d, 8'h44);
    stop_c();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
